// File: rtl/shift_seq_ctrl.sv
// Iterative 16-bit shift/rotate engine that applies one power-of-two stage per RUN cycle.
// Latency is popcount(Cnt)+1 cycles from accept to done, and start is ignored while busy.
module shift_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] In,
  input  logic [1:0]  Op,
  input  logic [3:0]  Cnt,
  output logic        busy,
  output logic        done,
  output logic [15:0] Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  rem_q, rem_d;

  logic [3:0]  stage_bit;
  logic [3:0]  rem_next;
  logic [4:0]  amt;
  logic [4:0]  amt_inv;
  logic [15:0] stage_res;

  // The largest remaining weight is consumed first; a stage amount of 0 leaves work unchanged.
  always_comb begin
    stage_bit = 4'b0000;
    if (rem_q[3])      stage_bit = 4'b1000;
    else if (rem_q[2]) stage_bit = 4'b0100;
    else if (rem_q[1]) stage_bit = 4'b0010;
    else if (rem_q[0]) stage_bit = 4'b0001;

    rem_next  = rem_q & ~stage_bit;
    amt       = {1'b0, stage_bit};
    amt_inv   = 5'd16 - amt;
    stage_res = work_q;

    case (op_q)
      OP_SLL:  stage_res = work_q << amt;
      OP_SRL:  stage_res = work_q >> amt;
      OP_ROL:  stage_res = (work_q << amt) | (work_q >> amt_inv);
      OP_ROR:  stage_res = (work_q >> amt) | (work_q << amt_inv);
      default: stage_res = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    rem_d   = rem_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = In;
          op_d    = Op;
          rem_d   = Cnt;
          state_d = (Cnt != 4'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        work_d = stage_res;
        rem_d  = rem_next;
        if (rem_next == 4'd0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 16'h0000;
      op_q    <= 2'b00;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  assign Out = work_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: vector table, corner-case sequences and random ops against a reference model.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic [1:0]  op;
  logic [3:0]  cnt;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int total = 0;
  int bad   = 0;

  logic [15:0] sb_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  shift_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (din),
    .Op    (op),
    .Cnt   (cnt),
    .busy  (busy),
    .done  (done),
    .Out   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_model(input logic [1:0] o, input logic [15:0] d, input logic [3:0] n);
    logic [31:0] dd;
    logic [31:0] sh;
    dd = {d, d};
    case (o)
      2'b00:   ref_model = d << n;
      2'b10:   ref_model = d >> n;
      2'b11:   begin sh = dd << n; ref_model = sh[31:16]; end
      default: begin sh = dd >> n; ref_model = sh[15:0]; end
    endcase
  endfunction

  // Starts an op in the current cycle, scrambles inputs afterwards, and checks done latency and result.
  task automatic run_op(input logic [1:0] o, input logic [15:0] d, input logic [3:0] n,
                        input logic [15:0] exp, input int exp_lat, input string nm);
    bit seen;
    logic [15:0] e;
    start = 1'b1; op = o; din = d; cnt = n;
    sb_q.push_back(exp);
    tick();
    start = 1'b0;
    din   = 16'($urandom);
    op    = 2'($urandom);
    cnt   = 4'($urandom);
    seen  = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) chk({nm, "_busy"}, 16'(busy), 16'd1);
      if (done) begin
        seen = 1'b1;
        chk({nm, "_lat"}, 16'(c), 16'(exp_lat));
        e = sb_q.pop_front();
        chk({nm, "_out"}, dout, e);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got=no_done required=done", nm);
      void'(sb_q.pop_front());
    end
    tick();
  endtask

  initial begin
    vecs[0]  = '{2'b00, 16'h00FF, 4'd4,  16'h0FF0, 2};
    vecs[1]  = '{2'b11, 16'h1234, 4'd15, 16'h091A, 5};
    vecs[2]  = '{2'b10, 16'h8000, 4'd9,  16'h0040, 3};
    vecs[3]  = '{2'b01, 16'hABCD, 4'd0,  16'hABCD, 1};
    vecs[4]  = '{2'b01, 16'h0001, 4'd1,  16'h8000, 2};
    vecs[5]  = '{2'b11, 16'h8001, 4'd1,  16'h0003, 2};
    vecs[6]  = '{2'b10, 16'hFFFF, 4'd15, 16'h0001, 5};
    vecs[7]  = '{2'b00, 16'hFFFF, 4'd8,  16'hFF00, 2};
    vecs[8]  = '{2'b01, 16'h1234, 4'd4,  16'h4123, 2};
    vecs[9]  = '{2'b11, 16'hABCD, 4'd8,  16'hCDAB, 2};
    vecs[10] = '{2'b00, 16'h1234, 4'd0,  16'h1234, 1};
    vecs[11] = '{2'b01, 16'h8000, 4'd15, 16'h0001, 5};

    // Reset with a simultaneous start: reset wins and the start is dropped.
    rst = 1'b1; start = 1'b1; din = 16'h1234; op = 2'b00; cnt = 4'd4;
    tick();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_out",  dout,      16'h0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // First table entry starts in the first cycle after reset release.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].din, vecs[i].cnt, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
      if (vecs[i].cnt == 4'd9) begin
        for (int h = 0; h < 7; h++) begin
          @(negedge clk);
          chk($sformatf("hold%0d_out", h), dout, 16'h0040);
          chk($sformatf("hold%0d_busy", h), 16'(busy), 16'd0);
        end
        tick();
      end
    end

    // Starts while busy must neither queue nor disturb the captured operands.
    start = 1'b1; op = 2'b00; din = 16'h0001; cnt = 4'd15;
    tick();
    for (int c = 1; c <= 4; c++) begin
      start = 1'b1; din = 16'hFFFF; cnt = 4'd1;
      @(negedge clk);
      chk($sformatf("drop_c%0d_done", c), 16'(done), 16'd0);
      chk($sformatf("drop_c%0d_busy", c), 16'(busy), 16'd1);
      tick();
    end
    start = 1'b0;
    @(negedge clk);
    chk("drop_c5_done", 16'(done), 16'd1);
    chk("drop_c5_out",  dout,      16'h8000);
    tick();
    @(negedge clk);
    chk("drop_c6_busy", 16'(busy), 16'd0);
    chk("drop_c6_done", 16'(done), 16'd0);
    tick();

    // Reset mid-operation aborts without done; a fresh start right after is honoured.
    start = 1'b1; op = 2'b01; din = 16'h00F0; cnt = 4'd7;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_out",  dout,      16'h0000);
    run_op(2'b10, 16'hF000, 4'd12, 16'h000F, 3, "abort_new");

    for (int r = 0; r < 24; r++) begin
      logic [1:0]  ro;
      logic [15:0] rd;
      logic [3:0]  rn;
      ro = 2'($urandom);
      rd = 16'($urandom);
      rn = 4'($urandom);
      run_op(ro, rd, rn, ref_model(ro, rd, rn), $countones(rn) + 1, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits and count width at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 In  input  16  operand, captured on accepted start.
REQ-006 Op  input  2  operation, captured on accepted start: 00 SLL, 01 ROR, 10 SRL, 11 ROL.
REQ-007 Cnt  input  4  shift/rotate amount 0..15, captured on accepted start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  single-cycle completion strobe.
REQ-010 Out  output  16  result register; valid when done=1; holds that value until the next accepted start.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 Start accept: start=1 while in IDLE; on that edge, latch In into the work register, and latch Op and Cnt into the op register and the remaining-count register.
REQ-013 Transition from IDLE on accept: to RUN if Cnt!=0, else to DONE.
REQ-014 RUN, each cycle: select the highest set bit of remaining count (weight 8, 4, 2 or 1); on the edge, apply exactly one stage of that weight to the work register and clear that bit.
REQ-015 Stage semantics for weight k: SLL shifts left k and zero-fills; SRL shifts right k and zero-fills; ROL rotates left k; ROR rotates right k. Bits SHALL NOT be lost under rotate.
REQ-016 Transition from RUN: to DONE on the edge where the remaining count becomes zero; otherwise remain in RUN.
REQ-017 DONE: done=1 for exactly that one cycle; next state is IDLE unconditionally.
REQ-018 Latency: if start is accepted in cycle 0, done=1 in cycle popcount(Cnt)+1.
- Minimum latency is 1 cycle (Cnt=0).
- Maximum latency is 5 cycles (Cnt=15).
REQ-019 Out SHALL reflect the work register.
- Intermediate values are visible during RUN, but are defined only when done=1.
- After DONE, Out is unchanged in IDLE until the next accept.
REQ-020 start in RUN or DONE SHALL be ignored: no queuing, no effect on captured operands. The earliest re-accept is the cycle after done.
REQ-021 In, Op and Cnt changes after accept SHALL NOT affect the operation in progress.
REQ-022 Result equivalence: Out at done SHALL equal the full 16-bit shift or rotate of the captured In by the captured Cnt.
- Cnt=0 yields In unchanged.
- ROL by n equals ROR by 16-n.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL set: state to IDLE, busy=0, done=0, Out=16'h0000, and the remaining count to 0.
REQ-024 Reset SHALL take priority over start and over any in-progress operation.
- An aborted operation never asserts done.
REQ-025 start asserted in the same cycle as rst SHALL be ignored.
REQ-026 start in the first cycle after rst deasserts SHALL be accepted.

Verification
REQ-027 SLL: In=16'h00FF, Cnt=4, start in cycle 0 -> busy=1 in cycle 1; done=1 with Out=16'h0FF0 in cycle 2.
REQ-028 ROL: In=16'h1234, Cnt=15 -> four RUN cycles; done=1 with Out=16'h091A in cycle 5.
REQ-029 SRL: In=16'h8000, Cnt=9 -> done=1 with Out=16'h0040 in cycle 3; Out still 16'h0040 in cycles 4-10 with start low.
REQ-030 ROR: In=16'hABCD, Cnt=0 -> done=1 with Out=16'hABCD in cycle 1, with no RUN cycle.
REQ-031 Busy-drop: SLL In=16'h0001, Cnt=15 accepted.
- Stimulus: start pulses with In=16'hFFFF, Cnt=1 in cycles 1-4.
- Required: done only in cycle 5, with Out=16'h8000.
- Required: busy=0 in cycle 6.
REQ-032 Reset mid-op: ROR In=16'h00F0, Cnt=7 accepted, rst=1 in cycle 2 -> cycle 3 has busy=0, done=0, Out=16'h0000; no done pulse follows.
- A new start in cycle 3 (SRL, In=16'hF000, Cnt=12) yields done with Out=16'h000F in cycle 6.
